// File: rtl/ecg_adc_axis_source_pkg.sv
// Shared definitions for the ECG ADC source: default rates, FIFO operation
// encoding and the offset-binary to left-justified two's complement conversion.
package ecg_adc_axis_source_pkg;

   localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
   localparam int unsigned DEF_FS_HZ       = 500;

   typedef enum logic [1:0] {
      FIFO_HOLD = 2'b00,
      FIFO_POP  = 2'b01,
      FIFO_PUSH = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

   // Flipping the MSB recentres offset binary on zero; the shift left-justifies it.
   function automatic logic [31:0] ob_to_signed(input logic [31:0] raw,
                                                input int unsigned adc_w,
                                                input int unsigned out_w);
      logic [31:0] r;
      r           = raw;
      r[adc_w-1]  = ~raw[adc_w-1];
      r           = r << (out_w - adc_w);
      return r;
   endfunction

endpackage

// File: rtl/ecg_adc_axis_source_axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with AXI4-Stream slave/master ports
// and an occupancy output; accepts a push into a full FIFO when a pop coincides.
module axis_sync_fifo
   import ecg_adc_axis_source_pkg::*;
#(
   parameter int unsigned width = 16,
   parameter int unsigned aw    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [width-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [aw:0]      level
);

   localparam int unsigned DEPTH = 2 ** aw;

   logic [width-1:0] mem_q [DEPTH];
   logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
   logic [aw:0]      level_q, level_d;
   logic             push, pop;
   fifo_op_e         op;

   assign m_axis_tvalid = (level_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
   // When full, a same-cycle pop frees the slot being written.
   assign s_axis_tready = (level_q != (aw+1)'(DEPTH)) || m_axis_tready;
   assign push          = s_axis_tvalid && s_axis_tready;
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign op            = fifo_op_e'({push, pop});
   assign level         = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      unique case (op)
         FIFO_PUSH: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            level_d  = level_q + 1'b1;
         end
         FIFO_POP: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            level_d  = level_q - 1'b1;
         end
         FIFO_BOTH: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
   end

endmodule

// File: rtl/ecg_adc_axis_source.sv
// ECG ADC front end: paces conversions at fs, converts offset-binary samples and
// streams them out through a FIFO, counting samples dropped on overflow.
module ecg_adc_axis_source
   import ecg_adc_axis_source_pkg::*;
#(
   parameter int unsigned clk_freq_hz = DEF_CLK_FREQ_HZ,
   parameter int unsigned fs_hz       = DEF_FS_HZ,
   parameter int unsigned adc_width   = 12,
   parameter int unsigned inout_width = 16,
   parameter int unsigned fifo_aw     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   output logic                   adc_convst,
   input  logic                   adc_drdy,
   input  logic [adc_width-1:0]   adc_data,
   output logic [inout_width-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   input  logic                   clr_ovf,
   output logic                   ovf_flag,
   output logic [15:0]            drop_count,
   output logic [fifo_aw:0]       fifo_level
);

   localparam int unsigned DIV   = clk_freq_hz / fs_hz;
   localparam int unsigned CNT_W = $clog2(DIV);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   convst_q, convst_d;
   logic                   ovf_q, ovf_d;
   logic [15:0]            drops_q, drops_d;
   logic [inout_width-1:0] sample;
   logic                   attempt, fifo_ready, drop;

   always_comb begin
      cnt_d    = '0;
      convst_d = 1'b0;
      if (enable) begin
         if (cnt_q == CNT_W'(DIV - 1)) convst_d = 1'b1;
         else                          cnt_d    = cnt_q + 1'b1;
      end
   end

   assign sample  = inout_width'(ob_to_signed(32'(adc_data), adc_width, inout_width));
   assign attempt = adc_drdy && enable;
   assign drop    = attempt && !fifo_ready;

   // A drop coinciding with clr_ovf restarts the count at one rather than zero.
   always_comb begin
      ovf_d   = ovf_q;
      drops_d = drops_q;
      if (drop) begin
         ovf_d   = 1'b1;
         drops_d = clr_ovf ? 16'd1 : ((drops_q == '1) ? drops_q : drops_q + 1'b1);
      end else if (clr_ovf) begin
         ovf_d   = 1'b0;
         drops_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         convst_q <= 1'b0;
         ovf_q    <= 1'b0;
         drops_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         convst_q <= convst_d;
         ovf_q    <= ovf_d;
         drops_q  <= drops_d;
      end
   end

   assign adc_convst = convst_q;
   assign ovf_flag   = ovf_q;
   assign drop_count = drops_q;

   axis_sync_fifo #(
      .width (inout_width),
      .aw    (fifo_aw)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (sample),
      .s_axis_tvalid (attempt),
      .s_axis_tready (fifo_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .level         (fifo_level)
   );

endmodule

// File: tb/tb_ecg_adc_axis_source.sv
// Self-checking bench for ecg_adc_axis_source: directed corner sequences plus
// random traffic checked every cycle against a queue-based reference model.
module tb_ecg_adc_axis_source;

   localparam int unsigned DIV   = 10;
   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        adc_drdy = 1'b0;
   logic [11:0] adc_data = '0;
   logic        m_axis_tready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        adc_convst;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        ovf_flag;
   logic [15:0] drop_count;
   logic [4:0]  fifo_level;

   ecg_adc_axis_source #(
      .clk_freq_hz (1000),
      .fs_hz       (100),
      .adc_width   (12),
      .inout_width (16),
      .fifo_aw     (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .adc_convst    (adc_convst),
      .adc_drdy      (adc_drdy),
      .adc_data      (adc_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .clr_ovf       (clr_ovf),
      .ovf_flag      (ovf_flag),
      .drop_count    (drop_count),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0] mq[$];
   logic        m_ovf = 1'b0;
   int          m_dc = 0;
   int          run_len = 0;
   logic        m_convst = 1'b0;

   typedef struct {
      logic [11:0] adc;
      logic [15:0] exp;
   } conv_vec_t;
   conv_vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Signed sample value is (code - midscale), scaled up by 2**(16-12).
   function automatic logic [15:0] conv(input logic [11:0] a);
      return 16'((int'(a) - 2048) * 16);
   endfunction

   task automatic check_all();
      chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
      chk("tdata", 32'(m_axis_tdata), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("level", 32'(fifo_level), 32'(mq.size()));
      chk("ovf", 32'(ovf_flag), 32'(m_ovf));
      chk("drops", 32'(drop_count), 32'(m_dc));
      chk("convst", 32'(adc_convst), 32'(m_convst));
   endtask

   task automatic model_edge();
      bit attempt, full, pop, drop;
      attempt = adc_drdy && enable;
      full    = (mq.size() == DEPTH);
      pop     = (mq.size() != 0) && m_axis_tready;
      drop    = attempt && full && !pop;
      if (pop) void'(mq.pop_front());
      if (attempt && !drop) mq.push_back(conv(adc_data));
      if (drop) begin
         m_ovf = 1'b1;
         m_dc  = clr_ovf ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
      end else if (clr_ovf) begin
         m_ovf = 1'b0;
         m_dc  = 0;
      end
      if (enable) begin
         run_len++;
         m_convst = (run_len % DIV == 0);
      end else begin
         run_len  = 0;
         m_convst = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [11:0] v);
      adc_data = v;
      adc_drdy = 1'b1;
      tick();
      adc_drdy = 1'b0;
   endtask

   initial begin
      int pulses;
      int first_at;
      logic [15:0] exp_seq[$];

      vecs[0] = '{12'h800, 16'h0000};
      vecs[1] = '{12'hFFF, 16'h7FF0};
      vecs[2] = '{12'h000, 16'h8000};
      vecs[3] = '{12'h801, 16'h0010};
      vecs[4] = '{12'h7FF, 16'hFFF0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ovf", 32'(ovf_flag), 32'd0);
      chk("rst_drops", 32'(drop_count), 32'd0);
      chk("rst_convst", 32'(adc_convst), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Conversion-start pacing, gating and restart.
      enable = 1'b1;
      m_axis_tready = 1'b1;
      pulses = 0;
      for (int i = 0; i < 35; i++) begin
         tick();
         if (adc_convst) pulses++;
      end
      chk("convst_pulses_run", 32'(pulses), 32'd3);
      enable = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (adc_convst) pulses++;
      end
      chk("convst_pulses_off", 32'(pulses), 32'd0);
      enable = 1'b1;
      pulses = 0;
      first_at = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (adc_convst) begin
            pulses++;
            if (first_at < 0) first_at = i;
         end
      end
      chk("convst_restart_pos", 32'(first_at), 32'd10);
      chk("convst_restart_cnt", 32'(pulses), 32'd1);

      // Offset-binary conversion table, one-cycle drdy->tvalid latency.
      for (int i = 0; i < 5; i++) begin
         push_one(vecs[i].adc);
         chk("conv_tvalid", 32'(m_axis_tvalid), 32'd1);
         chk("conv_tdata", 32'(m_axis_tdata), 32'(vecs[i].exp));
         tick();
      end

      // Fill to full with downstream stalled, then overflow.
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 16; i++) push_one(12'(i));
      chk("full_level", 32'(fifo_level), 32'd16);
      chk("full_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("full_head", 32'(m_axis_tdata), 32'h8010);
      tick();
      chk("full_head_stable", 32'(m_axis_tdata), 32'h8010);
      push_one(12'd17);
      chk("ovf_flag", 32'(ovf_flag), 32'd1);
      chk("ovf_count", 32'(drop_count), 32'd1);
      chk("ovf_level", 32'(fifo_level), 32'd16);

      // Push and pop together while full: no drop.
      m_axis_tready = 1'b1;
      push_one(12'd100);
      chk("both_level", 32'(fifo_level), 32'd16);
      chk("both_count", 32'(drop_count), 32'd1);
      for (int i = 2; i <= 16; i++) exp_seq.push_back(conv(12'(i)));
      exp_seq.push_back(conv(12'd100));
      for (int i = 0; i < 16; i++) begin
         chk("drain_order", 32'(m_axis_tdata), 32'(exp_seq[i]));
         tick();
      end
      chk("drain_empty", 32'(m_axis_tvalid), 32'd0);

      // Overflow clear, then clear colliding with a drop.
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_flag", 32'(ovf_flag), 32'd0);
      chk("clr_count", 32'(drop_count), 32'd0);
      m_axis_tready = 1'b0;
      for (int i = 0; i < 16; i++) push_one(12'(200 + i));
      clr_ovf = 1'b1;
      push_one(12'd300);
      clr_ovf = 1'b0;
      chk("clr_drop_flag", 32'(ovf_flag), 32'd1);
      chk("clr_drop_count", 32'(drop_count), 32'd1);

      // Asynchronous reset with 5 entries queued.
      m_axis_tready = 1'b1;
      repeat (11) tick();
      m_axis_tready = 1'b0;
      chk("pre_rst_level", 32'(fifo_level), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("async_rst_level", 32'(fifo_level), 32'd0);
      mq.delete();
      m_ovf = 1'b0;
      m_dc = 0;
      run_len = 0;
      m_convst = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_axis_tready = 1'b1;
      push_one(12'hABC);
      chk("post_rst_first", 32'(m_axis_tdata), 32'h2BC0);
      tick();

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         enable        = ($urandom_range(0, 99) < 95);
         adc_drdy      = ($urandom_range(0, 2) == 0);
         adc_data      = 12'($urandom);
         m_axis_tready = ($urandom_range(0, 3) < ((i / 500) % 2 == 0 ? 1 : 3));
         clr_ovf       = ($urandom_range(0, 99) == 0);
         tick();
      end
      adc_drdy = 1'b0;
      clr_ovf  = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
